chacha20_block: RTL and testbench

Sequential ChaCha20 block function wrapped around the quarter-round datapath. It builds the 16-word initial state from key, nonce and block counter, then runs the column and diagonal rounds iteratively, one round per cycle, using four quarter-round instances. It adds the initial state back in and presents one 512-bit keystream block on a valid/ready output. The downstream XOR/stream stage consumes this keystream.

---
 rtl/chacha20_pkg.sv | 42 ++++
 rtl/chacha20_qr.sv | 35 +++
 rtl/chacha20_block.sv | 135 +++++++++++++
 tb/tb_chacha20_block.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha20_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chacha20_pkg
//  Description : Shared types, sigma constants, quarter-round index tables
//                and the rotate-left helper for the ChaCha20 block function.
//  Revision    : 1.0 - initial release
// ============================================================================
package chacha20_pkg;

    typedef logic [31:0]        word_t;
    // Word i of the state occupies bits [32i+31:32i].
    typedef logic [15:0][31:0]  state_t;

    // "expand 32-byte k" as four little-endian words.
    localparam word_t SIGMA0 = 32'h61707865;
    localparam word_t SIGMA1 = 32'h3320646e;
    localparam word_t SIGMA2 = 32'h79622d32;
    localparam word_t SIGMA3 = 32'h6b206574;

    // Word indices (a, b, c, d) fed to quarter-round q in a column round.
    localparam logic [3:0] COL_IDX [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };

    // Word indices (a, b, c, d) fed to quarter-round q in a diagonal round.
    localparam logic [3:0] DIAG_IDX [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    // True rotate: bits leaving the MSB re-enter at the LSB.
    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/chacha20_qr.sv
`default_nettype none
// ============================================================================
//  Module      : chacha20_qr
//  Description : Combinational ChaCha quarter round (add / xor / rotate).
//  Revision    : 1.0 - initial release
// ============================================================================
module chacha20_qr
    import chacha20_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t a_new,
    output word_t b_new,
    output word_t c_new,
    output word_t d_new
);

    word_t a1, b1, c1, d1;

    // Four add-xor-rotate steps with rotations 16, 12, 8, 7.
    always_comb begin
        a1    = a + b;
        d1    = rotl(d ^ a1, 16);
        c1    = c + d1;
        b1    = rotl(b ^ c1, 12);
        a_new = a1 + b1;
        d_new = rotl(d1 ^ a_new, 8);
        c_new = c1 + d_new;
        b_new = rotl(b1 ^ c_new, 7);
    end

endmodule
`default_nettype wire

// File: rtl/chacha20_block.sv
`default_nettype none
// ============================================================================
//  Module      : chacha20_block
//  Description : Iterative ChaCha20 block function. One column or diagonal
//                round per cycle through four quarter-round instances, then
//                a feed-forward add and a valid/ready keystream output.
//  Revision    : 1.0 - initial release
// ============================================================================
module chacha20_block
    import chacha20_pkg::*;
#(
    // Total rounds (8, 12 or 20); each column or diagonal round counts as one.
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] keystream,
    output logic         busy
);

    localparam int            RCW        = $clog2(ROUNDS);
    localparam logic [RCW-1:0] LAST_ROUND = RCW'(ROUNDS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FEED  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state;
    logic [RCW-1:0]       round_cnt;
    state_t               init_st;
    state_t               work_st;
    state_t               seed;
    state_t               next_col;
    state_t               next_diag;
    state_t               next_work;
    state_t               ks_sum;
    logic [3:0][3:0][31:0] qr_in;
    logic [3:0][3:0][31:0] qr_out;
    logic                 diag_round;

    // Even round index is a column round, odd is a diagonal round.
    assign diag_round = round_cnt[0];

    // Initial state: sigma, key words 4..11, counter word 12, nonce 13..15.
    assign seed = {nonce, counter, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};

    // Four quarter rounds; inputs picked by round parity, outputs scattered
    // back to the same word positions they came from.
    generate
        for (genvar q = 0; q < 4; q++) begin : g_qr
            for (genvar p = 0; p < 4; p++) begin : g_word
                assign qr_in[q][p] = diag_round ? work_st[DIAG_IDX[q][p]]
                                                : work_st[COL_IDX[q][p]];
                assign next_col[COL_IDX[q][p]]   = qr_out[q][p];
                assign next_diag[DIAG_IDX[q][p]] = qr_out[q][p];
            end
            chacha20_qr u_qr (
                .a     (qr_in[q][0]),
                .b     (qr_in[q][1]),
                .c     (qr_in[q][2]),
                .d     (qr_in[q][3]),
                .a_new (qr_out[q][0]),
                .b_new (qr_out[q][1]),
                .c_new (qr_out[q][2]),
                .d_new (qr_out[q][3])
            );
        end
    endgenerate

    assign next_work = diag_round ? next_diag : next_col;

    // Feed-forward: independent 32-bit adds, no carry between words.
    generate
        for (genvar i = 0; i < 16; i++) begin : g_feed
            assign ks_sum[i] = work_st[i] + init_st[i];
        end
    endgenerate

    assign in_ready = (state == S_IDLE);
    assign busy     = (state == S_ROUND) || (state == S_FEED);

    // Control FSM together with the working/initial state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            round_cnt <= '0;
            init_st   <= '0;
            work_st   <= '0;
            keystream <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        init_st   <= seed;
                        work_st   <= seed;
                        round_cnt <= '0;
                        state     <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    work_st   <= next_work;
                    round_cnt <= round_cnt + RCW'(1);
                    if (round_cnt == LAST_ROUND) begin
                        state <= S_FEED;
                    end
                end
                S_FEED: begin
                    keystream <= ks_sum;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chacha20_block.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chacha20_block
//  Description : Directed, self-checking bench for chacha20_block and the
//                chacha20_qr quarter round, with a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chacha20_block;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] key = '0;
    logic [95:0]  nonce = '0;
    logic [31:0]  counter = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [511:0] keystream;
    logic         busy;

    logic [31:0]  qa = '0, qb = '0, qc = '0, qd = '0;
    logic [31:0]  qa_n, qb_n, qc_n, qd_n;

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [511:0] exp_q[$];

    always #5 clk = ~clk;

    chacha20_block #(.ROUNDS(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key       (key),
        .nonce     (nonce),
        .counter   (counter),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .keystream (keystream),
        .busy      (busy)
    );

    chacha20_qr u_qr_unit (
        .a     (qa),
        .b     (qb),
        .c     (qc),
        .d     (qd),
        .a_new (qa_n),
        .b_new (qb_n),
        .c_new (qc_n),
        .d_new (qd_n)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the ChaCha20 block function.
    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] mqr(input logic [31:0] a, b, c, d);
        a = a + b; d = rl(d ^ a, 16);
        c = c + d; b = rl(b ^ c, 12);
        a = a + b; d = rl(d ^ a, 8);
        c = c + d; b = rl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] model(input logic [255:0] k, input logic [95:0] n,
                                            input logic [31:0] c);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [127:0] t;
        logic [511:0] r;
        int           g4 [8][4];
        g4 = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
               '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32 * i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13 + i] = n[32 * i +: 32];
        x = s;
        for (int dr = 0; dr < 10; dr++) begin
            for (int g = 0; g < 8; g++) begin
                t = mqr(x[g4[g][0]], x[g4[g][1]], x[g4[g][2]], x[g4[g][3]]);
                x[g4[g][0]] = t[127:96];
                x[g4[g][1]] = t[95:64];
                x[g4[g][2]] = t[63:32];
                x[g4[g][3]] = t[31:0];
            end
        end
        for (int i = 0; i < 16; i++) r[32 * i +: 32] = x[i] + s[i];
        return r;
    endfunction

    // Present a request, wait (bounded) for acceptance and push the expectation.
    task automatic accept_req(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        bit seen;
        int w;
        key = k; nonce = n; counter = c; in_valid = 1'b1;
        w = 0;
        seen = 1'b0;
        while (!seen && w < 50) begin
            seen = in_ready;
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b0;
        check("accept", {511'b0, seen}, 512'd1);
        exp_q.push_back(model(k, n, c));
    endtask

    task automatic do_req(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                          output int lat);
        accept_req(k, n, c);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_out(input string tag);
        check({tag, "_queue"}, {511'b0, exp_q.size() != 0}, 512'd1);
        if (exp_q.size() != 0) check(tag, keystream, exp_q.pop_front());
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [255:0] k_rfc;
        logic [95:0]  n_rfc;
        logic [511:0] rfc_ks, held, b1, b2, e;
        logic [31:0]  ksw [16];
        logic [31:0]  reqs[$];
        int           lat, got, cyc, pulses;
        bit           stable, leak, seen;

        ksw = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
        for (int i = 0; i < 16; i++) rfc_ks[32 * i +: 32] = ksw[i];
        for (int i = 0; i < 8; i++) k_rfc[32 * i +: 32] = 32'h03020100 + 32'h04040404 * i;
        n_rfc = {32'h00000000, 32'h4a000000, 32'h09000000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {511'b0, in_ready}, 512'd1);
        check("rst_out_valid", {511'b0, out_valid}, 512'd0);
        check("rst_busy", {511'b0, busy}, 512'd0);
        check("rst_keystream", keystream, 512'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Quarter-round unit vector
        qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
        #1;
        check("qr_a", {480'b0, qa_n}, {480'b0, 32'hea2a92f4});
        check("qr_b", {480'b0, qb_n}, {480'b0, 32'hcb1cf8ce});
        check("qr_c", {480'b0, qc_n}, {480'b0, 32'h4581472e});
        check("qr_d", {480'b0, qd_n}, {480'b0, 32'h5881c4bb});

        // Known-answer block, latency and backpressure
        do_req(k_rfc, n_rfc, 32'd1, lat);
        check("latency", 512'(lat), 512'd21);
        check("rfc_block", keystream, rfc_ks);
        check("busy_done", {511'b0, busy}, 512'd0);
        held = keystream; stable = 1'b1; leak = 1'b0;
        in_valid = 1'b1; counter = 32'd99;
        repeat (10) begin
            @(posedge clk); #1;
            if (keystream !== held || !out_valid) stable = 1'b0;
            if (in_ready) leak = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_stable", {511'b0, stable}, 512'd1);
        check("bp_in_ready_low", {511'b0, leak}, 512'd0);
        take_out("rfc_scoreboard");
        check("hs_out_valid_clear", {511'b0, out_valid}, 512'd0);
        check("hs_in_ready_back", {511'b0, in_ready}, 512'd1);

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        reqs = '{32'd1, 32'd2};
        key = k_rfc; nonce = n_rfc;
        got = 0; cyc = 0; b1 = '0; b2 = '0;
        while (got < 2 && cyc < 200) begin
            if (out_valid) begin
                got++;
                if (got == 1) b1 = keystream; else b2 = keystream;
                check("b2b_queue", {511'b0, exp_q.size() != 0}, 512'd1);
                if (exp_q.size() != 0) check("b2b_block", keystream, exp_q.pop_front());
            end
            if (reqs.size() != 0) begin
                counter = reqs[0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            seen = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (seen) begin
                exp_q.push_back(model(k_rfc, n_rfc, reqs[0]));
                void'(reqs.pop_front());
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 512'(got), 512'd2);
        check("b2b_distinct", {511'b0, b1 !== b2}, 512'd1);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("b2b_no_dup", 512'(pulses), 512'd0);
        out_ready = 1'b0;

        // Reset during round 7
        accept_req(k_rfc, n_rfc, 32'd3);
        repeat (7) @(posedge clk);
        #2;
        check("pre_rst_busy", {511'b0, busy}, 512'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {511'b0, out_valid}, 512'd0);
        check("mid_rst_busy", {511'b0, busy}, 512'd0);
        check("mid_rst_keystream", keystream, 512'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(k_rfc, n_rfc, 32'd1, lat);
        check("post_rst_latency", 512'(lat), 512'd21);
        check("post_rst_rfc", keystream, rfc_ks);
        take_out("post_rst_scoreboard");

        // Different key/nonce pattern
        begin
            logic [255:0] kr;
            logic [95:0]  nr;
            for (int i = 0; i < 8; i++) kr[32 * i +: 32] = $urandom;
            for (int i = 0; i < 3; i++) nr[32 * i +: 32] = $urandom;
            do_req(kr, nr, 32'd7, lat);
            take_out("rand_key_block");
        end

        // Counter at its maximum value
        do_req(k_rfc, n_rfc, 32'hFFFFFFFF, lat);
        check("ctrmax_latency", 512'(lat), 512'd21);
        e = model(k_rfc, n_rfc, 32'hFFFFFFFF);
        check("ctrmax_word12", {480'b0, keystream[415:384]}, {480'b0, e[415:384]});
        take_out("ctrmax_block");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
